// File: rtl/ctrl_decode_pipe.sv
// Registered decode stage: opcode -> control bundle with valid/ready, stall,
// flush, load-use interlock, sticky illegal-opcode flag and a halt freeze.
module ctrl_decode_pipe #(
    parameter int INSTR_W  = 9,
    parameter int OP_W     = 5,
    parameter int REG_W    = 4,
    parameter int AOP_W    = 4,
    parameter int ADR_REG  = 4,
    parameter int MATH_REG = 5,
    parameter int CNT_REG  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               in_ready,
    input  logic               stall_in,
    input  logic               flush,
    output logic               out_valid,
    output logic [REG_W-1:0]   rd_reg0,
    output logic [REG_W-1:0]   rd_reg1,
    output logic [REG_W-1:0]   wr_reg,
    output logic               reg_write,
    output logic               move,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               branch,
    output logic               jump_sign,
    output logic               immediate,
    output logic               set_quarter,
    output logic               halt_out,
    output logic [AOP_W-1:0]   alu_op,
    output logic               halted,
    output logic               illegal
);

    typedef struct packed {
        logic [REG_W-1:0] rd0;
        logic [REG_W-1:0] rd1;
        logic [REG_W-1:0] wr;
        logic             reg_write;
        logic             move;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch;
        logic             jump_sign;
        logic             immediate;
        logic             set_quarter;
        logic             halt;
        logic [AOP_W-1:0] alu_op;
    } bundle_t;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    localparam logic [REG_W-1:0] ADR_A  = REG_W'(ADR_REG);
    localparam logic [REG_W-1:0] MATH_A = REG_W'(MATH_REG);
    localparam logic [REG_W-1:0] CNT_A  = REG_W'(CNT_REG);
    localparam logic [OP_W-1:0]  OP_JUMP = 5'h18;
    localparam logic [OP_W-1:0]  OP_HALT = 5'h1A;

    logic [OP_W-1:0]  op_s;
    logic [REG_W-1:0] ra_s;
    logic [REG_W-1:0] rb_s;
    logic [REG_W-1:0] imm_s;
    bundle_t          dec_s;
    logic             rd0_used_s;
    logic             rd1_used_s;
    logic             undef_s;
    logic             hazard_s;
    logic             accept_s;
    bundle_t          out_r;
    logic             out_valid_r;
    logic             illegal_r;
    state_t           state_r;
    state_t           state_next_s;

    assign op_s  = instr_in[INSTR_W-1 -: OP_W];
    assign ra_s  = REG_W'(instr_in[3:2]);
    assign rb_s  = REG_W'(instr_in[1:0]);
    assign imm_s = REG_W'(instr_in[3:0]);

    // Opcode decode into a control bundle plus operand-use flags
    always_comb begin
        dec_s      = '0;
        rd1_used_s = 1'b0;
        undef_s    = 1'b0;
        case (op_s)
            5'h00, 5'h01: begin
                dec_s.rd0 = ra_s; dec_s.rd1 = MATH_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op = (op_s == 5'h01) ? 4'd1 : 4'd0;
                rd1_used_s = 1'b1;
            end
            5'h02: begin
                dec_s.rd0 = ra_s; dec_s.rd1 = MATH_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h03: begin
                dec_s.rd0 = ra_s; dec_s.wr = ADR_A;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h04: begin
                dec_s.rd0 = ADR_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h05: begin
                dec_s.wr = ADR_A; dec_s.reg_write = 1'b1;
                dec_s.immediate = 1'b1; dec_s.jump_sign = instr_in[0];
            end
            5'h06: begin
                dec_s.rd0 = imm_s; dec_s.wr = MATH_A;
                dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1;
            end
            5'h07: begin
                dec_s.rd0 = MATH_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h08: begin
                dec_s.rd0 = ra_s; dec_s.wr = MATH_A;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h09: begin
                dec_s.rd0 = MATH_A; dec_s.rd1 = ra_s; dec_s.wr = ADR_A;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1;
                rd1_used_s = 1'b1;
            end
            5'h0A: begin
                dec_s.rd0 = MATH_A; dec_s.rd1 = ra_s; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1;
                rd1_used_s = 1'b1;
            end
            5'h0B: begin
                dec_s.rd0 = rb_s; dec_s.rd1 = ra_s; dec_s.wr = CNT_A;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1; dec_s.set_quarter = 1'b1;
                rd1_used_s = 1'b1;
            end
            5'h0C: begin
                dec_s.rd0 = CNT_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h0D: begin
                dec_s.rd0 = ra_s; dec_s.wr = CNT_A;
                dec_s.reg_write = 1'b1; dec_s.move = 1'b1;
            end
            5'h0E: begin
                dec_s.wr = CNT_A; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1;
            end
            5'h0F, 5'h10, 5'h11, 5'h12, 5'h13: begin
                dec_s.rd0 = ra_s; dec_s.rd1 = rb_s; dec_s.branch = 1'b1;
                rd1_used_s = 1'b1;
                case (op_s)
                    5'h0F:   dec_s.alu_op = 4'd7;
                    5'h10:   dec_s.alu_op = 4'd8;
                    5'h11:   dec_s.alu_op = 4'd6;
                    5'h12:   dec_s.alu_op = 4'd5;
                    default: dec_s.alu_op = 4'd4;
                endcase
            end
            5'h14, 5'h15: begin
                dec_s.rd0 = ra_s; dec_s.wr = rb_s;
                dec_s.alu_op = (op_s == 5'h15) ? 4'd3 : 4'd2;
            end
            5'h16: begin
                dec_s.rd0 = ra_s; dec_s.rd1 = ADR_A; dec_s.wr = rb_s;
                dec_s.reg_write = 1'b1; dec_s.mem_to_reg = 1'b1;
                rd1_used_s = 1'b1;
            end
            5'h17: begin
                dec_s.rd0 = ra_s; dec_s.rd1 = ADR_A; dec_s.wr = rb_s;
                dec_s.mem_write = 1'b1;
                rd1_used_s = 1'b1;
            end
            5'h18: begin
                dec_s.branch = 1'b1; dec_s.alu_op = 4'd7;
            end
            5'h19: begin
                dec_s.wr = rb_s; dec_s.reg_write = 1'b1; dec_s.immediate = 1'b1;
            end
            5'h1A: dec_s.halt = 1'b1;
            default: undef_s = 1'b1;
        endcase
        rd0_used_s = !dec_s.immediate && (op_s != OP_JUMP) && (op_s != OP_HALT);
    end

    // A load in the output register blocks a consumer of its destination
    assign hazard_s = out_valid_r && out_r.mem_to_reg &&
                      ((rd0_used_s && (dec_s.rd0 == out_r.wr)) ||
                       (rd1_used_s && (dec_s.rd1 == out_r.wr)));
    assign in_ready = !stall_in && !flush && !hazard_s && (state_r == ST_RUN);
    assign accept_s = in_valid && in_ready;

    // Output bundle register: flush beats stall beats accept; otherwise bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (stall_in) begin
            out_r       <= out_r;
            out_valid_r <= out_valid_r;
        end else if (accept_s) begin
            out_r       <= dec_s;
            out_valid_r <= 1'b1;
        end else begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end
    end

    // Sticky undefined-opcode flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (accept_s && undef_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Halt state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Halt next-state: HALTED is only left through reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && dec_s.halt) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    assign out_valid   = out_valid_r;
    assign rd_reg0     = out_r.rd0;
    assign rd_reg1     = out_r.rd1;
    assign wr_reg      = out_r.wr;
    assign reg_write   = out_r.reg_write;
    assign move        = out_r.move;
    assign mem_to_reg  = out_r.mem_to_reg;
    assign mem_write   = out_r.mem_write;
    assign branch      = out_r.branch;
    assign jump_sign   = out_r.jump_sign;
    assign immediate   = out_r.immediate;
    assign set_quarter = out_r.set_quarter;
    assign halt_out    = out_r.halt;
    assign alu_op      = out_r.alu_op;
    assign halted      = (state_r == ST_HALTED);
    assign illegal     = illegal_r;

endmodule
